// File: rtl/lsu_ctrl.sv
// Load/store initiator for the MEM stage: turns one pipeline memory request into
// data-memory accesses, with sub-word stores done as read-modify-write.
module lsu_ctrl #(
  parameter int unsigned DMEM_ADDR_WIDTH = 12,
  parameter int unsigned CHECK_ALIGN     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        mem_we,
  output logic [1:0]  mem_memlen,
  output logic [31:0] mem_daddr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;
  localparam bit         ALIGN_EN = (CHECK_ALIGN != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t state, state_next;

  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        we_q;
  logic        signed_q;
  logic [31:0] wdata_q;
  logic [1:0]  err_q;
  logic [31:0] old_q;

  logic        accept;
  logic        misalign_c;
  logic        range_c;
  logic [1:0]  err_c;
  logic [31:0] load_ext_c;
  logic [31:0] merge_c;

  logic        resp_valid_next;
  logic [31:0] resp_rdata_next;
  logic [1:0]  resp_err_next;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign mem_we    = (state == WRITE) && !rst;

  // Error classification of the incoming request, evaluated at acceptance.
  always_comb begin
    misalign_c = 1'b0;
    range_c    = (req_addr >> DMEM_ADDR_WIDTH) != 32'd0;
    case (req_size)
      SZ_ILL:  misalign_c = 1'b1;
      SZ_HALF: misalign_c = ALIGN_EN && req_addr[0];
      SZ_WORD: misalign_c = ALIGN_EN && (req_addr[1:0] != 2'b00);
      default: misalign_c = 1'b0;
    endcase
    err_c = {range_c, misalign_c};
  end

  // Load extension of the memory word and sub-word store merge.
  always_comb begin
    case (size_q)
      SZ_BYTE: load_ext_c = {{24{signed_q & mem_rdata[7]}}, mem_rdata[7:0]};
      SZ_HALF: load_ext_c = {{16{signed_q & mem_rdata[15]}}, mem_rdata[15:0]};
      default: load_ext_c = mem_rdata;
    endcase
    case (size_q)
      SZ_BYTE: merge_c = {old_q[31:8], wdata_q[7:0]};
      SZ_HALF: merge_c = {old_q[31:16], wdata_q[15:0]};
      default: merge_c = wdata_q;
    endcase
  end

  // Next-state, memory-side drive and next response values.
  always_comb begin
    state_next      = state;
    resp_valid_next = 1'b0;
    resp_rdata_next = resp_rdata;
    resp_err_next   = resp_err;
    mem_daddr       = 32'd0;
    mem_memlen      = SZ_WORD;
    mem_wdata       = 32'd0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (err_c != 2'b00) begin
            state_next      = RESP;
            resp_valid_next = 1'b1;
            resp_rdata_next = 32'd0;
            resp_err_next   = err_c;
          end else if (!req_we) begin
            state_next = LOAD;
          end else if (req_size == SZ_WORD) begin
            state_next = WRITE;
          end else begin
            state_next = RMW_RD;
          end
        end
      end
      LOAD: begin
        mem_daddr       = addr_q;
        mem_memlen      = size_q;
        state_next      = RESP;
        resp_valid_next = 1'b1;
        resp_rdata_next = load_ext_c;
        resp_err_next   = err_q;
      end
      RMW_RD: begin
        mem_daddr  = addr_q;
        mem_memlen = SZ_WORD;
        state_next = WRITE;
      end
      WRITE: begin
        mem_daddr       = addr_q;
        mem_memlen      = SZ_WORD;
        mem_wdata       = merge_c;
        state_next      = RESP;
        resp_valid_next = 1'b1;
        resp_rdata_next = 32'd0;
        resp_err_next   = err_q;
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, request capture and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= 32'd0;
      size_q     <= SZ_WORD;
      we_q       <= 1'b0;
      signed_q   <= 1'b0;
      wdata_q    <= 32'd0;
      err_q      <= 2'b00;
      old_q      <= 32'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 2'b00;
    end else begin
      state      <= state_next;
      resp_valid <= resp_valid_next;
      resp_rdata <= resp_rdata_next;
      resp_err   <= resp_err_next;
      if (accept) begin
        addr_q   <= req_addr;
        size_q   <= req_size;
        we_q     <= req_we;
        signed_q <= req_signed;
        wdata_q  <= req_wdata;
        err_q    <= err_c;
      end
      if (state == RMW_RD) begin
        old_q <= mem_rdata;
      end
    end
  end

  // we_q is kept for observability of the captured request; fold it in so it is not dangling.
  logic unused_ok;
  assign unused_ok = we_q;

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store initiator in the MEM stage. It converts one pipeline memory request into Dmem-side accesses: daddr, memlen, wdata and we out; combinational rdata back.
- Loads are sign- or zero-extended.
- Sub-word stores become a read-modify-write, because the data memory always writes four bytes starting at daddr.
- Misaligned and out-of-range requests are rejected with an error response and never reach memory.
- The core is stalled while req_ready is low.

Parameters:
DMEM_ADDR_WIDTH, 12, byte-address width of the data memory. An address with any bit at or above this width set is out of range.
CHECK_ALIGN, 1, when 1, half accesses at odd addresses and word accesses at addresses not 4-aligned are errors. When 0, no alignment errors are raised.

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  high only in IDLE; request is accepted on req_valid && req_ready
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 word, 01 byte, 10 half, 11 illegal; same encoding as memlen
req_signed  in  1  load sign-extend enable; ignored for stores and words
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  32  load result; 0 for stores and errors
resp_err  out  2  bit0 = misaligned or illegal size; bit1 = out of range
mem_we  out  1  Dmem write enable
mem_memlen  out  2  Dmem access size
mem_daddr  out  32  Dmem byte address
mem_wdata  out  32  Dmem write data
mem_rdata  in  32  Dmem read data, combinational from mem_daddr and mem_memlen

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- Request capture: on acceptance, addr, size, we, signed and wdata are registered. The error code is computed from the request fields at acceptance and registered.
- Transitions from IDLE on accept:
  - error nonzero -> RESP
  - load -> LOAD
  - store word -> WRITE
  - store byte/half -> RMW_RD
- Other transitions:
  - LOAD -> RESP
  - RMW_RD -> WRITE
  - WRITE -> RESP
  - RESP -> IDLE
- Error-free latency, accept cycle = cycle 0:
  - load: resp_valid in cycle 2
  - store word: mem_we in cycle 1, resp_valid in cycle 2
  - store byte/half: read in cycle 1, mem_we in cycle 2, resp_valid in cycle 3
- Errored request: resp_valid in cycle 1. mem_we never asserts and memory-side outputs are not driven.
- Memory-side outputs are driven from registered state.
  - LOAD: mem_daddr = addr, mem_memlen = size.
  - RMW_RD: mem_daddr = addr, mem_memlen = word.
  - WRITE: mem_daddr = addr, mem_memlen = word.
  - All other states: mem_daddr = 0, mem_memlen = 00, mem_wdata = 0.
- mem_we = (state == WRITE) && !rst. No write ever occurs in a cycle where rst is high.
- Load capture: mem_rdata is sampled at the end of the LOAD cycle.
  - Byte: bits [31:8] = req_signed ? rdata[7] : 0.
  - Half: bits [31:16] = req_signed ? rdata[15] : 0.
  - Word: passed unchanged.
- Store merge: the word read in RMW_RD is registered.
  - mem_wdata in WRITE = {old[31:8], wdata[7:0]} for byte, {old[31:16], wdata[15:0]} for half, wdata for word.
- Error rules:
  - Byte accesses never raise bit0.
  - Size 11 always raises bit0, regardless of CHECK_ALIGN.
  - Range check uses the addr bits [31:DMEM_ADDR_WIDTH].
  - Both error bits may be set together.
- resp_rdata and resp_err are valid only while resp_valid is high. They hold their values until the next response and are cleared by reset.
- req_ready is combinational from state (state == IDLE) and is 0 while rst is high. Requests presented when req_ready is low are ignored, and the requester must hold them.
- Reset values: state IDLE. resp_valid, resp_rdata, resp_err, mem_we, mem_memlen, mem_daddr and mem_wdata are all 0. req_ready is 0 during reset and 1 in the first cycle after reset.
- Reset mid-operation aborts the transaction: no response is issued and no memory write occurs.

Test Plan:
- Preload word at 0x10 = 0x8899AABB. Signed byte load at 0x10 -> resp_valid in cycle 2, resp_rdata = 0xFFFFFFBB, resp_err = 00. Unsigned half load at 0x10 -> 0x0000AABB.
- Byte store at 0x10 with wdata 0x12345677 -> mem_memlen = 00 in cycle 1; in cycle 2, mem_we = 1 and mem_wdata = 0x8899AA77; resp in cycle 3. A following word load at 0x10 returns 0x8899AA77.
- Word store at 0x20 with data 0xDEADBEEF -> mem_we only in cycle 1, resp in cycle 2. A half load at 0x22 returns 0x0000DEAD when signed = 0 and 0xFFFFDEAD when signed = 1.
- Word load at 0x12 and half load at 0x13 -> resp_err = 01 in cycle 1 and mem_we stays 0. Byte load at 0x13 -> no error. With CHECK_ALIGN = 0, word load at 0x12 -> no error.
- DMEM_ADDR_WIDTH = 12: load at 0x00001000 -> resp_err = 10. Size 11 at 0x1001 -> resp_err = 11. Neither request touches memory.
- rst asserted in the WRITE cycle of a word store to 0x30 -> mem_we = 0 in that cycle, the word at 0x30 is unchanged, no resp_valid follows, and req_ready = 1 in the first cycle after reset.
- Back-to-back requests held on req_valid -> each is accepted only in IDLE, with exactly one resp_valid per accept.
